fpu_norm_pipe: RTL and testbench

- Parametrised, pipelined successor to the adder-subtractor normalisation stage of the FPU.
- Takes two unpacked operands {sign, exp, mant} and orders them by magnitude (larger first).
- Left-normalises the smaller operand with exponent compensation and denormal clamping.
- Two-stage valid/ready pipeline with backpressure and flush, between operand unpack and the alignment shifter.

---
 rtl/fpu_norm_pkg.sv | 23 ++
 rtl/lzc_param.sv | 18 +
 rtl/fpu_norm_pipe.sv | 182 ++++++++++++++++++
 tb/tb_fpu_norm_pipe.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_norm_pkg.sv
// Shared definitions for fpu_norm_pipe: default widths, operand field slices,
// the default-width operand struct and the count-width helper.
package fpu_norm_pkg;

  localparam int EW_DEF = 8;
  localparam int MW_DEF = 28;

  localparam int SIGN_BIT = EW_DEF + MW_DEF;
  localparam int EXP_MSB  = EW_DEF + MW_DEF - 1;
  localparam int EXP_LSB  = MW_DEF;

  typedef struct packed {
    logic              sign;
    logic [EW_DEF-1:0] exp;
    logic [MW_DEF-1:0] mant;
  } fp_op_t;

  // Bits needed to hold a leading-zero count in the range 0..w.
  function automatic int clz_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/lzc_param.sv
// Combinational leading-zero counter; an all-zero input returns W.
module lzc_param #(
  parameter  int W    = 28,
  localparam int CNTW = $clog2(W + 1)
) (
  input  logic [W-1:0]    i_data,
  output logic [CNTW-1:0] o_cnt
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_cnt = CNTW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_cnt = CNTW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_norm_pipe.sv
// Two-stage magnitude-order and normalise stage of the FPU adder front end.
// Optional statistics counters are built only when FPU_NORM_STATS_EN is defined.
module fpu_norm_pipe
  import fpu_norm_pkg::*;
#(
  parameter  int EW  = EW_DEF,
  parameter  int MW  = MW_DEF,
  localparam int CW  = clz_w(MW),
  localparam int OPW = 1 + EW + MW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_sw,
  output logic [OPW-1:0] out_a,
  output logic [OPW-1:0] out_b,
  output logic [CW-1:0]  out_lz,
  output logic           out_zero,
  output logic           out_uflow
`ifdef FPU_NORM_STATS_EN
  ,
  output logic [15:0]    stat_swaps,
  output logic [15:0]    stat_uflows
`endif
);

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
  } op_t;

  if (EW < 2 || MW < 4) begin : g_bad_width
    $error("fpu_norm_pipe: EW=%0d MW=%0d out of range (need EW>=2, MW>=4)", EW, MW);
  end

  logic          r_s1_v;
  logic          r_s1_sw;
  op_t           r_s1_big;
  op_t           r_s1_small;
  logic [CW-1:0] r_s1_lz;

  logic           r_s2_v;
  logic           r_s2_sw;
  logic [OPW-1:0] r_s2_a;
  logic [OPW-1:0] r_s2_b;
  logic [CW-1:0]  r_s2_lz;
  logic           r_s2_zero;
  logic           r_s2_uflow;

  logic          w_s1_en;
  logic          w_s2_en;
  op_t           w_a;
  op_t           w_b;
  op_t           w_big;
  op_t           w_small;
  logic          w_sw;
  logic [CW-1:0] w_lz;

  assign w_s2_en  = !r_s2_v || out_ready;
  assign w_s1_en  = !r_s1_v || w_s2_en;
  assign in_ready = w_s1_en;

  // Stage 1: order by unsigned {exp, mant}; a tie keeps A as the larger.
  assign w_a     = op_t'(in_a);
  assign w_b     = op_t'(in_b);
  assign w_sw    = {w_b.exp, w_b.mant} > {w_a.exp, w_a.mant};
  assign w_big   = w_sw ? w_b : w_a;
  assign w_small = w_sw ? w_a : w_b;

  lzc_param #(.W(MW)) u_lzc (
    .i_data (w_small.mant),
    .o_cnt  (w_lz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v     <= 1'b0;
      r_s1_sw    <= 1'b0;
      r_s1_big   <= '0;
      r_s1_small <= '0;
      r_s1_lz    <= '0;
    end else begin
      if (flush)        r_s1_v <= 1'b0;
      else if (w_s1_en) r_s1_v <= in_valid;
      if (w_s1_en && in_valid && !flush) begin
        r_s1_sw    <= w_sw;
        r_s1_big   <= w_big;
        r_s1_small <= w_small;
        r_s1_lz    <= w_lz;
      end
    end
  end

  // Stage 2: shift by the LZ count, clamped so the exponent never goes below 0.
  logic [EW+CW-1:0] w_lz_x;
  logic [EW+CW-1:0] w_exp_x;
  logic [CW-1:0]    w_sh;
  logic             w_zero;
  logic             w_uflow;
  op_t              w_nb;

  assign w_lz_x  = {{EW{1'b0}}, r_s1_lz};
  assign w_exp_x = {{CW{1'b0}}, r_s1_small.exp};

  always_comb begin
    w_zero  = (r_s1_small.mant == '0);
    w_uflow = 1'b0;
    w_sh    = r_s1_lz;
    w_nb    = r_s1_small;
    if (!w_zero) begin
      if (w_lz_x > w_exp_x) begin
        w_uflow = 1'b1;
        w_sh    = w_exp_x[CW-1:0];
      end
      w_nb.mant    = r_s1_small.mant << w_sh;
      w_nb.mant[0] = 1'b1;
      w_nb.exp     = w_uflow ? '0 : r_s1_small.exp - w_lz_x[EW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v     <= 1'b0;
      r_s2_sw    <= 1'b0;
      r_s2_a     <= '0;
      r_s2_b     <= '0;
      r_s2_lz    <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_uflow <= 1'b0;
    end else begin
      if (flush)        r_s2_v <= 1'b0;
      else if (w_s2_en) r_s2_v <= r_s1_v;
      if (w_s2_en && r_s1_v && !flush) begin
        r_s2_sw    <= r_s1_sw;
        r_s2_a     <= r_s1_big;
        r_s2_b     <= w_nb;
        r_s2_lz    <= w_sh;
        r_s2_zero  <= w_zero;
        r_s2_uflow <= w_uflow;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign out_sw    = r_s2_sw;
  assign out_a     = r_s2_a;
  assign out_b     = r_s2_b;
  assign out_lz    = r_s2_lz;
  assign out_zero  = r_s2_zero;
  assign out_uflow = r_s2_uflow;

`ifdef FPU_NORM_STATS_EN
  logic [15:0] r_stat_swaps;
  logic [15:0] r_stat_uflows;
  logic        w_out_xfer;

  assign w_out_xfer = r_s2_v && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_swaps  <= '0;
      r_stat_uflows <= '0;
    end else begin
      if (w_out_xfer && r_s2_sw && r_stat_swaps != 16'hFFFF)
        r_stat_swaps <= r_stat_swaps + 16'd1;
      if (w_out_xfer && r_s2_uflow && r_stat_uflows != 16'hFFFF)
        r_stat_uflows <= r_stat_uflows + 16'd1;
    end
  end

  assign stat_swaps  = r_stat_swaps;
  assign stat_uflows = r_stat_uflows;
`endif

endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Self-checking bench for fpu_norm_pipe against an arithmetic reference model.
module tb_fpu_norm_pipe;
  import fpu_norm_pkg::*;

  localparam int EW  = EW_DEF;
  localparam int MW  = MW_DEF;
  localparam int CW  = clz_w(MW);
  localparam int OPW = 1 + EW + MW;

  typedef struct packed {
    logic           sw;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [CW-1:0]  lz;
    logic           zero;
    logic           uflow;
  } res_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_a;
  logic [OPW-1:0] in_b;
  logic           out_valid;
  logic           out_ready;
  logic           out_sw;
  logic [OPW-1:0] out_a;
  logic [OPW-1:0] out_b;
  logic [CW-1:0]  out_lz;
  logic           out_zero;
  logic           out_uflow;
`ifdef FPU_NORM_STATS_EN
  logic [15:0]    stat_swaps;
  logic [15:0]    stat_uflows;
`endif

  fpu_norm_pipe #(.EW(EW), .MW(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sw    (out_sw),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_lz    (out_lz),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
`ifdef FPU_NORM_STATS_EN
    ,
    .stat_swaps  (stat_swaps),
    .stat_uflows (stat_uflows)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t q[$];

  logic s_in_ready;
  logic s_out_valid;
  logic s_in_xfer;
  logic s_out_xfer;
  logic s_unexp;
  int   s_qsize;
  res_t s_act;
  res_t s_exp;

  function automatic logic [OPW-1:0] mk(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m);
    fp_op_t o;
    o.sign = s;
    o.exp  = e;
    o.mant = m;
    return o;
  endfunction

  // Reference: order by magnitude, then normalise with plain integer arithmetic.
  function automatic res_t ref_model(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    res_t            r;
    logic [OPW-1:0]  sm;
    longint unsigned m;
    int              e, lz, sh;
    r.sw    = (b[EXP_MSB:0] > a[EXP_MSB:0]);
    r.a     = r.sw ? b : a;
    sm      = r.sw ? a : b;
    e       = int'(sm[EXP_MSB:EXP_LSB]);
    m       = sm[MW-1:0];
    r.zero  = 1'b0;
    r.uflow = 1'b0;
    if (m == 0) begin
      r.zero = 1'b1;
      r.lz   = CW'(MW);
      r.b    = sm;
    end else begin
      lz = MW - $clog2(m + 1);
      if (lz > e) begin
        sh      = e;
        r.uflow = 1'b1;
      end else begin
        sh = lz;
      end
      m    = (m << sh) | 1;
      r.b  = {sm[SIGN_BIT], EW'(e - sh), MW'(m)};
      r.lz = CW'(sh);
    end
    return r;
  endfunction

  function automatic logic [OPW-1:0] rand_op();
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    int            k;
    e = EW'($urandom);
    if ($urandom_range(0, 2) == 0) e = EW'($urandom_range(0, 8));
    k = $urandom_range(0, 5);
    case (k)
      0:       m = '0;
      1:       m = MW'(1) << $urandom_range(0, MW - 1);
      default: m = MW'($urandom) >> $urandom_range(0, MW - 1);
    endcase
    return mk(1'($urandom), e, m);
  endfunction

  // One clock: drive at the falling edge, sample 1 time unit later, then advance.
  task automatic step(input logic v, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    flush     = fl;
    #1;
    s_qsize     = q.size();
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_act.sw    = out_sw;
    s_act.a     = out_a;
    s_act.b     = out_b;
    s_act.lz    = out_lz;
    s_act.zero  = out_zero;
    s_act.uflow = out_uflow;
    s_in_xfer   = v && in_ready && !fl && !rst;
    s_out_xfer  = out_valid && ordy && !fl && !rst;
    s_unexp     = 1'b0;
    if (s_out_xfer) begin
      if (q.size() == 0) s_unexp = 1'b1;
      else s_exp = q.pop_front();
    end
    if (s_in_xfer) q.push_back(ref_model(a, b));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    q.delete();
    step(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++;
    if (s_in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", s_in_ready);
    else n_pass++;
    n_checks++;
    if (s_out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", s_out_valid);
    else n_pass++;
    n_checks++;
    if (s_act !== '0) $display("FAIL reset data: got %h want 0", s_act);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [OPW-1:0] va[4];
    logic [OPW-1:0] vb[4];
    res_t           ve[4];
    va[0] = mk(1'b0, 8'd10, 28'h8000000);
    vb[0] = mk(1'b0, 8'd5,  28'h0100000);
    ve[0] = '{sw: 1'b0, a: va[0], b: mk(1'b0, 8'd0, 28'h2000001), lz: CW'(5), zero: 1'b0, uflow: 1'b1};
    va[1] = mk(1'b0, 8'd3,  28'h0000001);
    vb[1] = mk(1'b0, 8'd9,  28'h4000000);
    ve[1] = '{sw: 1'b1, a: vb[1], b: mk(1'b0, 8'd0, 28'h0000009), lz: CW'(3), zero: 1'b0, uflow: 1'b1};
    va[2] = mk(1'b0, 8'd30, 28'h1234567);
    vb[2] = mk(1'b1, 8'd20, 28'h0000000);
    ve[2] = '{sw: 1'b0, a: va[2], b: vb[2], lz: CW'(28), zero: 1'b1, uflow: 1'b0};
    va[3] = mk(1'b0, 8'd100, 28'h8000000);
    vb[3] = mk(1'b1, 8'd50,  28'h0000F00);
    ve[3] = '{sw: 1'b0, a: va[3], b: mk(1'b1, 8'd34, 28'hF000001), lz: CW'(16), zero: 1'b0, uflow: 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, va[i], vb[i], 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++;
      if (s_out_valid !== 1'b0) $display("FAIL directed[%0d] early out_valid: got %b want 0", i, s_out_valid);
      else n_pass++;
      step(1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++;
      if (s_out_valid !== 1'b1) $display("FAIL directed[%0d] latency out_valid: got %b want 1", i, s_out_valid);
      else n_pass++;
      n_checks++;
      if (s_act !== ve[i]) $display("FAIL directed[%0d] data: got %h want %h", i, s_act, ve[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [OPW-1:0] pa[4];
    logic [OPW-1:0] pb[4];
    int   sent = 0, got = 0, cyc = 0, n_low = 0;
    logic ordy, exp_rdy;
    for (int i = 0; i < 4; i++) begin
      pa[i] = rand_op();
      pb[i] = rand_op();
    end
    while ((sent < 4 || got < 4) && cyc < 40) begin
      ordy = !(cyc >= 3 && cyc <= 5);
      step(sent < 4, pa[sent < 4 ? sent : 0], pb[sent < 4 ? sent : 0], ordy, 1'b0);
      exp_rdy = (s_qsize < 2) || ordy;
      if (!s_in_ready) n_low++;
      n_checks++;
      if (s_in_ready !== exp_rdy) $display("FAIL b2b[%0d] in_ready: got %b want %b", cyc, s_in_ready, exp_rdy);
      else n_pass++;
      if (s_out_xfer) begin
        n_checks++;
        if (s_unexp) $display("FAIL b2b[%0d] order: got extra result %h want none", cyc, s_act);
        else if (s_act !== s_exp) $display("FAIL b2b[%0d] order: got %h want %h", cyc, s_act, s_exp);
        else n_pass++;
        got++;
      end
      if (s_in_xfer) sent++;
      cyc++;
    end
    n_checks++;
    if (got !== 4 || q.size() !== 0) $display("FAIL b2b count: got %0d results want 4 (left %0d)", got, q.size());
    else n_pass++;
    n_checks++;
    if (n_low !== 3) $display("FAIL b2b stall cycles: got %0d want 3", n_low);
    else n_pass++;
  endtask

  task automatic test_throughput();
    logic exp_v;
    for (int i = 0; i < 12; i++) begin
      step(i < 8, rand_op(), rand_op(), 1'b1, 1'b0);
      exp_v = (i >= 2 && i <= 9);
      n_checks++;
      if (s_out_valid !== exp_v) $display("FAIL thru[%0d] out_valid: got %b want %b", i, s_out_valid, exp_v);
      else n_pass++;
      if (s_out_xfer) begin
        n_checks++;
        if (s_unexp || s_act !== s_exp) $display("FAIL thru[%0d] data: got %h want %h", i, s_act, s_exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_flush();
    int n_seen = 0;
    step(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
    step(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
    step(1'b1, rand_op(), rand_op(), 1'b0, 1'b1);
    q.delete();
    step(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (s_out_valid !== 1'b0) $display("FAIL flush next out_valid: got %b want 0", s_out_valid);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      if (s_out_valid) n_seen++;
    end
    n_checks++;
    if (n_seen !== 0) $display("FAIL flush leak: got %0d results want 0", n_seen);
    else n_pass++;
    step(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
    step(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
    rst = 1'b0;
    q.delete();
    step(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1)
      $display("FAIL midrst handshake: got v=%b r=%b want v=0 r=1", s_out_valid, s_in_ready);
    else n_pass++;
    n_checks++;
    if (s_act !== '0) $display("FAIL midrst data: got %h want 0", s_act);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [OPW-1:0] a, b;
    logic v, ordy, exp_rdy;
    int   n_out = 0;
    for (int i = 0; i < 400; i++) begin
      a = rand_op();
      b = ($urandom_range(0, 9) == 0) ? a : rand_op();
      v    = (i < 370) && ($urandom_range(0, 9) < 7);
      ordy = (i >= 370) || ($urandom_range(0, 9) < 7);
      step(v, a, b, ordy, 1'b0);
      exp_rdy = (s_qsize < 2) || ordy;
      n_checks++;
      if (s_in_ready !== exp_rdy) $display("FAIL rand[%0d] in_ready: got %b want %b", i, s_in_ready, exp_rdy);
      else n_pass++;
      if (s_out_xfer) begin
        n_out++;
        n_checks++;
        if (s_unexp) $display("FAIL rand[%0d] data: got extra %h want none", i, s_act);
        else if (s_act !== s_exp) $display("FAIL rand[%0d] data: got %h want %h", i, s_act, s_exp);
        else n_pass++;
      end
    end
    n_checks++;
    if (q.size() !== 0 || n_out == 0) $display("FAIL rand drain: got %0d pending want 0 (out %0d)", q.size(), n_out);
    else n_pass++;
  endtask

`ifdef FPU_NORM_STATS_EN
  task automatic test_stats();
    logic [OPW-1:0] a, b;
    a = mk(1'b0, 8'd5, 28'h0000001);
    b = mk(1'b0, 8'd9, 28'h4000000);
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) step(1'b1, a, b, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (stat_swaps !== 16'd3 || stat_uflows !== 16'd3)
      $display("FAIL stats count: got %h/%h want 0003/0003", stat_swaps, stat_uflows);
    else n_pass++;
    for (int i = 0; i < 65540; i++) step(1'b1, a, b, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++;
    if (stat_swaps !== 16'hFFFF || stat_uflows !== 16'hFFFF)
      $display("FAIL stats saturate: got %h/%h want ffff/ffff", stat_swaps, stat_uflows);
    else n_pass++;
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    q.delete();
    n_checks++;
    if (stat_swaps !== 16'd0 || stat_uflows !== 16'd0)
      $display("FAIL stats reset: got %h/%h want 0000/0000", stat_swaps, stat_uflows);
    else n_pass++;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_throughput();
    test_flush();
    test_random();
`ifdef FPU_NORM_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
